alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 29 ++
 rtl/alu_sequencer.sv | 98 +++++++++
 tb/tb_alu_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU operand/result bus and debug read port of the ALU sequencer.
// The master side issues instructions and models the external ALU; the sequencer is the slave.
interface alu_sequencer_if;
  logic       InstrValid;
  logic       InstrReady;
  logic [2:0] Rd;
  logic [2:0] Rs;
  logic [2:0] Rt;
  logic [7:0] Imm;
  logic       UseImm;
  logic [7:0] Mux1Output;
  logic [7:0] ReadData2;
  logic       ALUOp;
  logic [7:0] ALUOutput;
  logic       Done;
  logic [7:0] WriteData;
  logic [2:0] DbgAddr;
  logic [7:0] DbgData;

  modport master (
    output InstrValid, Rd, Rs, Rt, Imm, UseImm, ALUOutput, DbgAddr,
    input  InstrReady, Mux1Output, ReadData2, ALUOp, Done, WriteData, DbgData
  );

  modport slave (
    input  InstrValid, Rd, Rs, Rt, Imm, UseImm, ALUOutput, DbgAddr,
    output InstrReady, Mux1Output, ReadData2, ALUOp, Done, WriteData, DbgData
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state sequencer: accepts an instruction, reads operands from a small register file,
// hands them to an external ALU and writes the result back one instruction at a time.
module alu_sequencer #(
  parameter int NUM_REGS = 8
) (
  input logic            clk,
  input logic            reset,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t     state, state_nxt;
  logic [7:0] regs [NUM_REGS];

  logic [2:0] rd_p0, rs_p0, rt_p0;
  logic [7:0] imm_p0;
  logic       use_imm_p0;
  logic [7:0] op1_p1, op2_p1;
  logic [7:0] wdata_p2;

  logic ready, alu_op, done, accept;

  // Register 0 and any address beyond the implemented file read as zero.
  function automatic logic [7:0] rf_read(input logic [2:0] addr, input logic [7:0] val);
    return (addr == 3'd0 || int'(addr) >= NUM_REGS) ? 8'h00 : val;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    alu_op    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = !reset;
        if (bus.InstrValid && !reset) state_nxt = READ;
      end
      READ: state_nxt = EXEC;
      EXEC: begin
        alu_op    = 1'b1;
        state_nxt = WB;
      end
      WB: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = ready && bus.InstrValid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_p0      <= '0;
      rs_p0      <= '0;
      rt_p0      <= '0;
      imm_p0     <= '0;
      use_imm_p0 <= 1'b0;
      op1_p1     <= '0;
      op2_p1     <= '0;
      wdata_p2   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      // p0: instruction captured on accept, isolated from later input changes
      if (accept) begin
        rd_p0      <= bus.Rd;
        rs_p0      <= bus.Rs;
        rt_p0      <= bus.Rt;
        imm_p0     <= bus.Imm;
        use_imm_p0 <= bus.UseImm;
      end
      // p1: operands read before any writeback of this instruction
      if (state == READ) begin
        op1_p1 <= use_imm_p0 ? imm_p0 : rf_read(rs_p0, regs[rs_p0]);
        op2_p1 <= rf_read(rt_p0, regs[rt_p0]);
      end
      // p2: ALU result captured at the end of EXEC
      if (state == EXEC) wdata_p2 <= bus.ALUOutput;
      if (state == WB && rd_p0 != 3'd0 && int'(rd_p0) < NUM_REGS) regs[rd_p0] <= wdata_p2;
    end
  end

  assign bus.InstrReady = ready;
  assign bus.ALUOp      = alu_op;
  assign bus.Done       = done;
  assign bus.Mux1Output = op1_p1;
  assign bus.ReadData2  = op2_p1;
  assign bus.WriteData  = wdata_p2;
  assign bus.DbgData    = rf_read(bus.DbgAddr, regs[bus.DbgAddr]);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, hand-written back-to-back and reset-in-flight
// sequences, then random instructions against an array-based register model.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer #(.NUM_REGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External ALU: adds while requested, returns a wrong value otherwise.
  logic [7:0] alu_sum;
  assign alu_sum       = bus.Mux1Output + bus.ReadData2;
  assign bus.ALUOutput = bus.ALUOp ? alu_sum : ~alu_sum;

  int checks = 0;
  int passed = 0;

  logic [7:0] model [8];

  typedef struct {
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [7:0] imm;
    logic       ui;
    logic [7:0] exp_wd;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] mread(input logic [2:0] a);
    return (a == 3'd0) ? 8'h00 : model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.InstrReady !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", {31'd0, bus.InstrReady}, 32'd1);
  endtask

  task automatic run_instr(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                           input logic [7:0] imm, input logic ui, input logic [7:0] exp_wd);
    logic [7:0] op1, op2;
    op1 = ui ? imm : mread(rs);
    op2 = mread(rt);
    wait_ready();
    bus.InstrValid = 1'b1;
    bus.Rd = rd; bus.Rs = rs; bus.Rt = rt; bus.Imm = imm; bus.UseImm = ui;
    @(posedge clk); #1;
    bus.InstrValid = 1'b0;
    bus.Rd = ~rd; bus.Rs = ~rs; bus.Rt = ~rt; bus.Imm = ~imm; bus.UseImm = ~ui;
    check("read_aluop", {31'd0, bus.ALUOp}, 32'd0);
    check("read_done", {31'd0, bus.Done}, 32'd0);
    check("read_ready", {31'd0, bus.InstrReady}, 32'd0);
    @(posedge clk); #1;
    check("exec_aluop", {31'd0, bus.ALUOp}, 32'd1);
    check("exec_done", {31'd0, bus.Done}, 32'd0);
    check("exec_op1", {24'd0, bus.Mux1Output}, {24'd0, op1});
    check("exec_op2", {24'd0, bus.ReadData2}, {24'd0, op2});
    @(posedge clk); #1;
    check("wb_done", {31'd0, bus.Done}, 32'd1);
    check("wb_aluop", {31'd0, bus.ALUOp}, 32'd0);
    check("wb_wdata", {24'd0, bus.WriteData}, {24'd0, exp_wd});
    check("wb_op1_held", {24'd0, bus.Mux1Output}, {24'd0, op1});
    @(posedge clk); #1;
    check("idle_done", {31'd0, bus.Done}, 32'd0);
    check("idle_ready", {31'd0, bus.InstrReady}, 32'd1);
    if (rd != 3'd0) model[rd] = exp_wd;
    bus.DbgAddr = rd;
    #1;
    check("dbg_rd", {24'd0, bus.DbgData}, {24'd0, mread(rd)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

  initial begin
    int acc_edges[$];
    int n_aluop, n_done;
    logic [2:0] rd, rs, rt;
    logic [7:0] imm, op1, op2;
    logic ui;

    vecs[0] = '{3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 8'h05};
    vecs[1] = '{3'd2, 3'd0, 3'd0, 8'h20, 1'b1, 8'h20};
    vecs[2] = '{3'd1, 3'd0, 3'd0, 8'hF0, 1'b1, 8'hF0};
    vecs[3] = '{3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 8'h10};
    vecs[4] = '{3'd0, 3'd0, 3'd0, 8'h7F, 1'b1, 8'h7F};
    vecs[5] = '{3'd1, 3'd0, 3'd0, 8'h03, 1'b1, 8'h03};
    vecs[6] = '{3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 8'h06};
    vecs[7] = '{3'd4, 3'd0, 3'd3, 8'h00, 1'b0, 8'h10};
    vecs[8] = '{3'd5, 3'd0, 3'd4, 8'hFF, 1'b1, 8'h0F};

    reset = 1'b1;
    bus.InstrValid = 1'b0;
    bus.Rd = '0; bus.Rs = '0; bus.Rt = '0; bus.Imm = '0; bus.UseImm = 1'b0;
    bus.DbgAddr = '0;
    clear_model();

    #1;
    check("rst_ready", {31'd0, bus.InstrReady}, 32'd0);
    check("rst_done", {31'd0, bus.Done}, 32'd0);
    check("rst_aluop", {31'd0, bus.ALUOp}, 32'd0);
    check("rst_op1", {24'd0, bus.Mux1Output}, 32'd0);
    check("rst_op2", {24'd0, bus.ReadData2}, 32'd0);
    check("rst_wdata", {24'd0, bus.WriteData}, 32'd0);
    bus.InstrValid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ready_held", {31'd0, bus.InstrReady}, 32'd0);
    bus.InstrValid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_release_ready", {31'd0, bus.InstrReady}, 32'd1);

    for (int v = 0; v < 9; v++)
      run_instr(vecs[v].rd, vecs[v].rs, vecs[v].rt, vecs[v].imm, vecs[v].ui, vecs[v].exp_wd);

    // InstrValid held high: accepts only from IDLE, every fourth edge, R1 doubling
    wait_ready();
    bus.InstrValid = 1'b1;
    bus.Rd = 3'd1; bus.Rs = 3'd1; bus.Rt = 3'd1; bus.UseImm = 1'b0; bus.Imm = 8'hAA;
    n_aluop = 0;
    n_done  = 0;
    for (int e = 0; e < 12; e++) begin
      if (bus.InstrReady === 1'b1) acc_edges.push_back(e);
      if (bus.ALUOp === 1'b1) n_aluop++;
      if (bus.Done === 1'b1) n_done++;
      @(posedge clk); #1;
    end
    bus.InstrValid = 1'b0;
    check("b2b_accepts", acc_edges.size(), 32'd3);
    if (acc_edges.size() == 3) begin
      check("b2b_gap1", acc_edges[1] - acc_edges[0], 32'd4);
      check("b2b_gap2", acc_edges[2] - acc_edges[1], 32'd4);
    end else begin
      check("b2b_gaps_present", acc_edges.size(), 32'd3);
    end
    check("b2b_aluop_cycles", n_aluop, 32'd3);
    check("b2b_done_cycles", n_done, 32'd3);
    model[1] = 8'h30;
    bus.DbgAddr = 3'd1;
    #1;
    check("b2b_r1", {24'd0, bus.DbgData}, 32'h30);

    // Reset in EXEC: outputs cleared at once, no Done, destination untouched
    wait_ready();
    bus.InstrValid = 1'b1;
    bus.Rd = 3'd6; bus.Rs = 3'd0; bus.Rt = 3'd0; bus.Imm = 8'h55; bus.UseImm = 1'b1;
    @(posedge clk); #1;
    bus.InstrValid = 1'b0;
    @(posedge clk); #1;
    check("mid_exec_aluop", {31'd0, bus.ALUOp}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_aluop", {31'd0, bus.ALUOp}, 32'd0);
    check("mid_rst_done", {31'd0, bus.Done}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.InstrReady}, 32'd0);
    check("mid_rst_op1", {24'd0, bus.Mux1Output}, 32'd0);
    check("mid_rst_op2", {24'd0, bus.ReadData2}, 32'd0);
    check("mid_rst_wdata", {24'd0, bus.WriteData}, 32'd0);
    bus.DbgAddr = 3'd1;
    #1;
    check("mid_rst_r1_cleared", {24'd0, bus.DbgData}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("rst_hold_done", {31'd0, bus.Done}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    #1;
    check("post_rst_ready", {31'd0, bus.InstrReady}, 32'd1);
    bus.DbgAddr = 3'd6;
    #1;
    check("post_rst_r6", {24'd0, bus.DbgData}, 32'd0);
    @(posedge clk); #1;
    check("post_rst_no_done", {31'd0, bus.Done}, 32'd0);

    // Random instructions against the register model
    for (int r = 0; r < 40; r++) begin
      rd  = 3'($urandom_range(0, 7));
      rs  = 3'($urandom_range(0, 7));
      rt  = 3'($urandom_range(0, 7));
      imm = 8'($urandom);
      ui  = 1'($urandom_range(0, 1));
      op1 = ui ? imm : mread(rs);
      op2 = mread(rt);
      run_instr(rd, rs, rt, imm, ui, 8'((int'(op1) + int'(op2)) % 256));
    end
    for (int a = 0; a < 8; a++) begin
      bus.DbgAddr = 3'(a);
      #1;
      check("final_reg", {24'd0, bus.DbgData}, {24'd0, mread(3'(a))});
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
